// File: rtl/csa_acc_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : csa_acc_pkg
//  Description : Shared types, default sizes and helpers for the carry-save
//                multi-operand accumulator.
//  Revision    : 1.0  initial release
// ============================================================================
package csa_acc_pkg;

    // Default parameter values for the accumulator top.
    localparam int DEF_WIDTH = 4;
    localparam int DEF_ACC_W = 8;
    localparam int DEF_CNT_W = 8;

    // Controller states.
    typedef enum logic [1:0] {
        ACCUM   = 2'd0,
        RESOLVE = 2'd1,
        DONE    = 2'd2
    } state_t;

    // Increment v, saturating at 2^w-1 (w up to 32).
    function automatic logic [31:0] sat_inc(input logic [31:0] v, input int unsigned w);
        logic [31:0] max_v;
        max_v = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
        return (v >= max_v) ? max_v : (v + 32'd1);
    endfunction

endpackage : csa_acc_pkg
`default_nettype wire

// File: rtl/csa_3to2.sv
`default_nettype none
// ============================================================================
//  Module      : csa_3to2
//  Description : Purely combinational row of N full adders (3:2 compressor).
//                sum = a^b^c, cy = maj(a,b,c), carry left unshifted so the
//                parent owns the shift and truncation.
//  Revision    : 1.0  initial release
// ============================================================================
module csa_3to2 #(
    parameter int N = 8
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic [N-1:0] c,
    output logic [N-1:0] sum,
    output logic [N-1:0] cy
);

    // Bitwise full-adder sum and majority carry.
    always_comb begin
        sum = a ^ b ^ c;
        cy  = (a & b) | (a & c) | (b & c);
    end

endmodule : csa_3to2
`default_nettype wire

// File: rtl/csa_accumulator.sv
`default_nettype none
// ============================================================================
//  Module      : csa_accumulator
//  Description : Streaming multi-operand accumulator holding the running total
//                in carry-save form; the last operand of a group triggers an
//                iterative resolve of S/C into a binary result.
//                Optional macro CSA_ACC_OVF_EN builds the sticky overflow flag;
//                without it out_ovf is tied to 0.
//  Revision    : 1.0  initial release
// ============================================================================
module csa_accumulator
    import csa_acc_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int ACC_W = DEF_ACC_W,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_sum,
    output logic [CNT_W-1:0] out_count,
    output logic             out_ovf
);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [ACC_W-1:0]   r_s;
    logic [ACC_W-1:0]   r_c;
    logic [CNT_W-1:0]   r_cnt;

    logic [ACC_W-1:0]   w_x;
    logic [ACC_W-1:0]   w_c_in;
    logic [ACC_W-1:0]   w_sum;
    logic [ACC_W-1:0]   w_cy;
    logic               w_accept;
    logic               w_c_zero;

    assign w_x      = ACC_W'(in_data);
    assign w_accept = in_valid && in_ready;
    assign w_c_zero = (r_c == '0);
    // Third compressor input is the operand while accumulating and zero while
    // resolving, so one row serves both S^C^X and S^C / S&C.
    assign w_c_in   = (r_state == ACCUM) ? w_x : '0;

    csa_3to2 #(
        .N   (ACC_W)
    ) u_csa (
        .a   (r_s),
        .b   (r_c),
        .c   (w_c_in),
        .sum (w_sum),
        .cy  (w_cy)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ACCUM;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode and handshake/result outputs.
    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        out_sum     = '0;
        out_count   = '0;
        case (r_state)
            ACCUM: begin
                in_ready = !rst;
                if (w_accept && in_last) begin
                    w_state_nxt = RESOLVE;
                end
            end
            RESOLVE: begin
                if (w_c_zero) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                out_sum   = r_s;
                out_count = r_cnt;
                if (out_ready) begin
                    w_state_nxt = ACCUM;
                end
            end
            default: begin
                w_state_nxt = ACCUM;
            end
        endcase
    end

    // Redundant accumulator and operand counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s   <= '0;
            r_c   <= '0;
            r_cnt <= '0;
        end else begin
            case (r_state)
                ACCUM: begin
                    if (w_accept) begin
                        r_s   <= w_sum;
                        r_c   <= w_cy << 1;
                        r_cnt <= CNT_W'(sat_inc(32'(r_cnt), CNT_W));
                    end
                end
                RESOLVE: begin
                    if (!w_c_zero) begin
                        r_s <= w_sum;
                        r_c <= w_cy << 1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_s   <= '0;
                        r_c   <= '0;
                        r_cnt <= '0;
                    end
                end
                default: begin
                    r_s   <= '0;
                    r_c   <= '0;
                    r_cnt <= '0;
                end
            endcase
        end
    end

`ifdef CSA_ACC_OVF_EN
    logic r_ovf;

    // Sticky overflow: every carry shifted out of the MSB is worth 2^ACC_W.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ovf <= 1'b0;
        end else begin
            case (r_state)
                ACCUM: begin
                    if (w_accept) begin
                        r_ovf <= r_ovf | w_cy[ACC_W-1];
                    end
                end
                RESOLVE: begin
                    if (!w_c_zero) begin
                        r_ovf <= r_ovf | w_cy[ACC_W-1];
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_ovf <= 1'b0;
                    end
                end
                default: begin
                    r_ovf <= 1'b0;
                end
            endcase
        end
    end

    assign out_ovf = (r_state == DONE) ? r_ovf : 1'b0;
`else
    assign out_ovf = 1'b0;
`endif

endmodule : csa_accumulator
`default_nettype wire
